alu_ctrl: RTL and testbench

Multi-cycle controller that sequences the shared `LEN`-bit ALU (4-bit `code`, codes 0–8 valid) for a small register machine. It accepts one operation at a time over a valid/ready handshake, holds an internal register file, and drives the ALU's `A`, `B` and `code` inputs over a fixed state sequence. It captures the ALU result, writes it back and pulses `done`. It sits between the instruction source (bench or future fetch unit) and the ALU instance.

---
 rtl/alu_ctrl_pkg.sv | 15 +
 rtl/ctrl_regfile.sv | 45 ++++
 rtl/alu_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants and FSM state type for the ALU sequencing controller.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_LDI     = 4'd9;
   localparam logic [3:0] OP_MOV     = 4'd10;
   localparam logic [3:0] ALU_OP_MAX = 4'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOADA = 2'd1,
      EXEC  = 2'd2,
      WB    = 2'd3
   } state_t;

endpackage

// File: rtl/ctrl_regfile.sv
// NREG x LEN register file: one write port, three combinational read ports,
// asynchronous active-high clear.
module ctrl_regfile
   import alu_ctrl_pkg::*;
#(
   parameter int LEN  = 8,
   parameter int NREG = 4,
   localparam int RW  = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_wr_en,
   input  logic [RW-1:0]  i_wr_idx,
   input  logic [LEN-1:0] i_wr_data,
   input  logic [RW-1:0]  i_rd_b_idx,
   output logic [LEN-1:0] o_rd_b_data,
   input  logic [RW-1:0]  i_rd_a_idx,
   output logic [LEN-1:0] o_rd_a_data,
   input  logic [RW-1:0]  i_rd_o_idx,
   output logic [LEN-1:0] o_rd_o_data
);

   logic [LEN-1:0] w_words [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         logic [LEN-1:0] r_word;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_word <= '0;
            else if (i_wr_en && (i_wr_idx == RW'(gi)))
               r_word <= i_wr_data;
         end

         assign w_words[gi] = r_word;
      end
   endgenerate

   assign o_rd_b_data = w_words[i_rd_b_idx];
   assign o_rd_a_data = w_words[i_rd_a_idx];
   assign o_rd_o_data = w_words[i_rd_o_idx];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle controller sequencing an external ALU over a small register file:
// ALU ops take IDLE->LOADA->EXEC->WB, LDI/MOV go IDLE->WB, illegal ops pulse err.
module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int LEN  = 8,
   parameter int NREG = 4,
   localparam int RW  = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [3:0]     req_op,
   input  logic [RW-1:0]  req_rx,
   input  logic [RW-1:0]  req_ry,
   input  logic [LEN-1:0] req_imm,
   output logic [LEN-1:0] alu_a,
   output logic [LEN-1:0] alu_b,
   output logic [3:0]     alu_code,
   input  logic [LEN-1:0] alu_out,
   output logic           done,
   output logic           err,
   input  logic [RW-1:0]  rd_sel,
   output logic [LEN-1:0] rd_data
);

   state_t         r_state;
   state_t         w_state_next;
   logic [LEN-1:0] r_a;
   logic [LEN-1:0] r_g;
   logic [3:0]     r_op_l;
   logic [RW-1:0]  r_rx_l;
   logic [RW-1:0]  r_ry_l;
   logic           r_done;
   logic           r_err;

   logic           w_accept;
   logic           w_is_alu;
   logic           w_is_ldi;
   logic           w_is_mov;
   logic           w_is_ill;
   logic           w_wr_en;
   logic [RW-1:0]  w_a_idx;
   logic [LEN-1:0] w_a_data;
   logic [LEN-1:0] w_b_data;

   assign req_ready = (r_state == IDLE) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_is_alu  = (req_op <= ALU_OP_MAX);
   assign w_is_ldi  = (req_op == OP_LDI);
   assign w_is_mov  = (req_op == OP_MOV);
   assign w_is_ill  = (req_op > OP_MOV);

   // The A-load port is idle while waiting for a request, so it serves the MOV source read.
   assign w_a_idx = (r_state == IDLE) ? req_ry : r_rx_l;

   ctrl_regfile #(
      .LEN  (LEN),
      .NREG (NREG)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (r_rx_l),
      .i_wr_data   (r_g),
      .i_rd_b_idx  (r_ry_l),
      .o_rd_b_data (w_b_data),
      .i_rd_a_idx  (w_a_idx),
      .o_rd_a_data (w_a_data),
      .i_rd_o_idx  (rd_sel),
      .o_rd_o_data (rd_data)
   );

   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_alu)
                  w_state_next = LOADA;
               else if (w_is_ldi || w_is_mov)
                  w_state_next = WB;
            end
         end
         LOADA: w_state_next = EXEC;
         EXEC:  w_state_next = WB;
         WB: begin
            w_wr_en      = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_g     <= '0;
         r_op_l  <= '0;
         r_rx_l  <= '0;
         r_ry_l  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_wr_en;
         r_err   <= w_accept && w_is_ill;
         if (w_accept) begin
            r_op_l <= req_op;
            r_rx_l <= req_rx;
            r_ry_l <= req_ry;
            if (w_is_ldi)
               r_g <= req_imm;
            else if (w_is_mov)
               r_g <= w_a_data;
         end
         if (r_state == LOADA)
            r_a <= w_a_data;
         if (r_state == EXEC)
            r_g <= alu_out;
      end
   end

   assign alu_a    = r_a;
   assign alu_b    = w_b_data;
   assign alu_code = r_op_l;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural ALU stub and register-file model.
module tb_alu_ctrl;

   localparam int LEN  = 8;
   localparam int NREG = 4;
   localparam int RW   = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [3:0]     req_op;
   logic [RW-1:0]  req_rx;
   logic [RW-1:0]  req_ry;
   logic [LEN-1:0] req_imm;
   logic [LEN-1:0] alu_a;
   logic [LEN-1:0] alu_b;
   logic [3:0]     alu_code;
   logic [LEN-1:0] alu_out;
   logic           done;
   logic           err;
   logic [RW-1:0]  rd_sel;
   logic [LEN-1:0] rd_data;

   logic           stub_fixed;
   logic [LEN-1:0] stub_val;
   logic [LEN-1:0] model_r [NREG];
   int             n_checks = 0;
   int             n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [LEN-1:0] ref_alu(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                                              input logic [3:0] c);
      case (c)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << 1;
         4'd6: return a >> 1;
         4'd7: return ~a;
         4'd8: return a * b;
         default: return '0;
      endcase
   endfunction

   assign alu_out = stub_fixed ? stub_val : ref_alu(alu_a, alu_b, alu_code);

   alu_ctrl #(.LEN(LEN), .NREG(NREG)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_rx    (req_rx),
      .req_ry    (req_ry),
      .req_imm   (req_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_code  (alu_code),
      .alu_out   (alu_out),
      .done      (done),
      .err       (err),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input int idx, output logic [LEN-1:0] val);
      rd_sel = RW'(idx);
      #1;
      val = rd_data;
   endtask

   // Issues one request from IDLE and observes six cycles after the accepting edge.
   task automatic run_op(input logic [3:0] op, input int rx, input int ry, input logic [LEN-1:0] imm,
                         output logic ready_ok, output int done_at, output int n_done,
                         output int n_err, output int n_both, output logic ready_k1,
                         output logic [LEN-1:0] ex_a, output logic [LEN-1:0] ex_b,
                         output logic [3:0] ex_code);
      ready_ok  = req_ready;
      req_valid = 1'b1;
      req_op    = op;
      req_rx    = RW'(rx);
      req_ry    = RW'(ry);
      req_imm   = imm;
      cycle();
      req_valid = 1'b0;
      req_op    = 4'($urandom);
      req_rx    = RW'($urandom);
      req_ry    = RW'($urandom);
      req_imm   = LEN'($urandom);
      done_at = -1; n_done = 0; n_err = 0; n_both = 0;
      ready_k1 = req_ready;
      ex_a = '0; ex_b = '0; ex_code = '0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) begin
            ex_a = alu_a; ex_b = alu_b; ex_code = alu_code;
         end
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         if (err) n_err++;
         if (done && err) n_both++;
         cycle();
      end
      $display("txn op=%0d rx=%0d ry=%0d imm=%02h done_at=%0d err_cycles=%0d", op, rx, ry, imm,
               done_at, n_err);
   endtask

   task automatic test_reset();
      logic [LEN-1:0] v;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rx = '0; req_ry = '0; req_imm = '0;
      rd_sel = '0; stub_fixed = 1'b0; stub_val = '0;
      for (int i = 0; i < NREG; i++) model_r[i] = '0;
      repeat (3) cycle();
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
      n_checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", done, err);
      end
      n_checks++;
      if (alu_a !== '0 || alu_b !== '0 || alu_code !== '0) begin
         n_fail++; $display("FAIL reset_alu_drive: got a=%h b=%h code=%h expected 0", alu_a, alu_b, alu_code);
      end
      for (int i = 0; i < NREG; i++) begin
         read_reg(i, v);
         n_checks++;
         if (v !== '0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
      end
      cycle();
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", req_ready); end
      cycle();
   endtask

   task automatic test_ldi();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      n_checks++;
      if (alu_a !== '0 || alu_b !== '0 || alu_code !== '0) begin
         n_fail++; $display("FAIL pre_req_alu_drive: got a=%h b=%h code=%h expected 0", alu_a, alu_b, alu_code);
      end
      run_op(4'd9, 1, 0, 8'h04, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      model_r[1] = 8'h04;
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL ldi_ready: got %b expected 1", ok); end
      n_checks++;
      if (da != 2 || nd != 1) begin n_fail++; $display("FAIL ldi_done: got at=%0d count=%0d expected at=2 count=1", da, nd); end
      read_reg(1, v);
      n_checks++;
      if (v !== 8'h04) begin n_fail++; $display("FAIL ldi_r1: got %h expected 04", v); end
   endtask

   task automatic test_alu_op();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      run_op(4'd9, 2, 0, 8'h01, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      model_r[2] = 8'h01;
      stub_fixed = 1'b1; stub_val = 8'hA5;
      run_op(4'd3, 1, 2, 8'h00, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      stub_fixed = 1'b0;
      model_r[1] = 8'hA5;
      n_checks++;
      if (ea !== 8'h04 || eb !== 8'h01 || ec !== 4'd3) begin
         n_fail++; $display("FAIL exec_drive: got a=%h b=%h code=%h expected a=04 b=01 code=3", ea, eb, ec);
      end
      n_checks++;
      if (da != 4 || nd != 1) begin n_fail++; $display("FAIL alu_done: got at=%0d count=%0d expected at=4 count=1", da, nd); end
      read_reg(1, v);
      n_checks++;
      if (v !== 8'hA5) begin n_fail++; $display("FAIL alu_r1: got %h expected a5", v); end
   endtask

   task automatic test_back_to_back();
      int acc = 0; int acc_cyc [2]; int n_done = 0; logic [LEN-1:0] v;
      logic [LEN-1:0] exp2, exp3;
      exp2 = ref_alu(model_r[2], model_r[1], 4'd0);
      exp3 = ref_alu(model_r[3], exp2, 4'd4);
      req_valid = 1'b1; req_op = 4'd0; req_rx = 2'd2; req_ry = 2'd1;
      acc_cyc[0] = -1; acc_cyc[1] = -1;
      for (int c = 0; c < 14; c++) begin
         if (done) n_done++;
         if (req_valid && req_ready) begin
            if (acc < 2) acc_cyc[acc] = c;
            if (acc == 1) begin
               n_checks++;
               if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_on_done: got done=%b expected 1", done); end
            end
            acc++;
         end
         cycle();
         if (acc == 1) begin req_op = 4'd4; req_rx = 2'd3; req_ry = 2'd2; end
         if (acc >= 2) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      model_r[2] = exp2; model_r[3] = exp3;
      $display("txn back_to_back accepts at %0d and %0d, done count %0d", acc_cyc[0], acc_cyc[1], n_done);
      n_checks++;
      if (acc != 2 || acc_cyc[1] - acc_cyc[0] != 4) begin
         n_fail++; $display("FAIL b2b_spacing: got accepts=%0d gap=%0d expected 2 and 4", acc, acc_cyc[1] - acc_cyc[0]);
      end
      n_checks++;
      if (n_done != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
      read_reg(2, v);
      n_checks++;
      if (v !== exp2) begin n_fail++; $display("FAIL b2b_r2: got %h expected %h", v, exp2); end
      read_reg(3, v);
      n_checks++;
      if (v !== exp3) begin n_fail++; $display("FAIL b2b_r3: got %h expected %h", v, exp3); end
   endtask

   task automatic test_mov();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      run_op(4'd9, 1, 0, 8'h5A, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      model_r[1] = 8'h5A;
      run_op(4'd10, 3, 1, 8'hFF, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      model_r[3] = model_r[1];
      n_checks++;
      if (da != 2 || nd != 1) begin n_fail++; $display("FAIL mov_done: got at=%0d count=%0d expected at=2 count=1", da, nd); end
      read_reg(3, v);
      n_checks++;
      if (v !== 8'h5A) begin n_fail++; $display("FAIL mov_r3: got %h expected 5a", v); end
   endtask

   task automatic test_illegal();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      run_op(4'd12, 2, 3, 8'h77, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      n_checks++;
      if (ne != 1 || nd != 0) begin n_fail++; $display("FAIL illegal_pulses: got err=%0d done=%0d expected 1 0", ne, nd); end
      n_checks++;
      if (rk1 !== 1'b1 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL illegal_ready: got %b/%b expected 1/1", rk1, req_ready);
      end
      for (int i = 0; i < NREG; i++) begin
         read_reg(i, v);
         n_checks++;
         if (v !== model_r[i]) begin n_fail++; $display("FAIL illegal_reg%0d: got %h expected %h", i, v, model_r[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      int n_done = 0;
      run_op(4'd9, 1, 0, 8'h07, ok, da, nd, ne, nb, rk1, ea, eb, ec);
      req_valid = 1'b1; req_op = 4'd0; req_rx = 2'd1; req_ry = 2'd2;
      cycle();
      req_valid = 1'b0;
      cycle();
      rst = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", req_ready); end
      read_reg(1, v);
      n_checks++;
      if (v !== '0) begin n_fail++; $display("FAIL midrst_r1: got %h expected 00", v); end
      cycle();
      if (done) n_done++;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < NREG; i++) model_r[i] = '0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got %b expected 1", req_ready); end
      for (int c = 0; c < 5; c++) begin
         if (done) n_done++;
         cycle();
      end
      $display("txn reset during EXEC, done count afterwards %0d", n_done);
      n_checks++;
      if (n_done != 0) begin n_fail++; $display("FAIL midrst_done: got %0d expected 0", n_done); end
      read_reg(1, v);
      n_checks++;
      if (v !== '0) begin n_fail++; $display("FAIL midrst_r1_after: got %h expected 00", v); end
   endtask

   task automatic test_random();
      logic ok, rk1; int da, nd, ne, nb; logic [LEN-1:0] ea, eb, v; logic [3:0] ec;
      logic [3:0] op; int rx, ry; logic [LEN-1:0] imm;
      int exp_da, exp_ne;
      for (int t = 0; t < 40; t++) begin
         op  = 4'($urandom_range(0, 15));
         rx  = int'($urandom_range(0, NREG - 1));
         ry  = int'($urandom_range(0, NREG - 1));
         imm = LEN'($urandom);
         run_op(op, rx, ry, imm, ok, da, nd, ne, nb, rk1, ea, eb, ec);
         exp_ne = 0;
         if (op <= 4'd8) begin
            model_r[rx] = ref_alu(model_r[rx], model_r[ry], op);
            exp_da = 4;
         end else if (op == 4'd9) begin
            model_r[rx] = imm;
            exp_da = 2;
         end else if (op == 4'd10) begin
            model_r[rx] = model_r[ry];
            exp_da = 2;
         end else begin
            exp_da = -1;
            exp_ne = 1;
         end
         n_checks++;
         if (da != exp_da || ne != exp_ne || nb != 0) begin
            n_fail++;
            $display("FAIL rand_timing t=%0d op=%0d: got done_at=%0d err=%0d both=%0d expected %0d %0d 0",
                     t, op, da, ne, nb, exp_da, exp_ne);
         end
         for (int i = 0; i < NREG; i++) begin
            read_reg(i, v);
            n_checks++;
            if (v !== model_r[i]) begin
               n_fail++; $display("FAIL rand_reg t=%0d r%0d: got %h expected %h", t, i, v, model_r[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_alu_op();
      test_back_to_back();
      test_mov();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
